// File: rtl/game_render_pkg.sv
// game_render_pkg
//   Shared types and constants for the 2048 background render path.
//   fade_state_t : brightness sequencer states
//   LEVEL_MAX    : full brightness level (palette colour unchanged)
//   PIPE_LAT     : draw coordinate to DAC colour latency in pixel clocks
//   scale_colour : 4-bit channel scaled by a 0..16 level
package game_render_pkg;

    typedef enum logic [1:0] {
        BLACK,
        FADE_IN,
        SHOWN,
        FADE_OUT
    } fade_state_t;

    localparam int unsigned LEVEL_MAX = 16;
    localparam int unsigned PIPE_LAT  = 3;

    // (c * lvl) >> 4 on a 9-bit product; lvl = 16 returns c unchanged.
    function automatic logic [3:0] scale_colour(input logic [3:0] c, input logic [4:0] lvl);
        return 4'((9'(c) * 9'(lvl)) >> 4);
    endfunction

endpackage

// File: rtl/game_render_ctrl_fade.sv
// fade_level_fsm
//   Frame-synchronous brightness sequencer. Level only moves on frame_start.
//   Ports:
//     clk, reset_n              pixel clock, async active-low reset
//     frame_start               start-of-vblank pulse
//     fade_in_req/fade_out_req  one-cycle requests (fade_out_req has priority)
//     level                     brightness 0..16
//     busy                      high while fading
//     fade_done                 one-cycle pulse when a fade completes
module fade_level_fsm
    import game_render_pkg::*;
#(
    parameter int unsigned FADE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       fade_in_req,
    input  logic       fade_out_req,
    output logic [4:0] level,
    output logic       busy,
    output logic       fade_done
);

    localparam int unsigned CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    fade_state_t      state;
    logic [CNT_W-1:0] step_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BLACK;
            step_cnt  <= '0;
            level     <= '0;
            busy      <= 1'b0;
            fade_done <= 1'b0;
        end else begin
            fade_done <= 1'b0;
            if (fade_out_req && (state == FADE_IN || state == SHOWN)) begin
                state    <= FADE_OUT;
                step_cnt <= '0;
                busy     <= 1'b1;
            end else if (fade_in_req && !fade_out_req && (state == FADE_OUT || state == BLACK)) begin
                state    <= FADE_IN;
                step_cnt <= '0;
                busy     <= 1'b1;
            end else if (frame_start && (state == FADE_IN || state == FADE_OUT)) begin
                if (step_cnt == CNT_W'(FADE_FRAMES - 1)) begin
                    step_cnt <= '0;
                    // Bound tests use >= / <= so a reversal parked at an end level still finishes.
                    if (state == FADE_IN) begin
                        if (level < 5'(LEVEL_MAX)) level <= level + 5'd1;
                        if (level >= 5'(LEVEL_MAX - 1)) begin
                            state     <= SHOWN;
                            busy      <= 1'b0;
                            fade_done <= 1'b1;
                        end
                    end else begin
                        if (level != '0) level <= level - 5'd1;
                        if (level <= 5'd1) begin
                            state     <= BLACK;
                            busy      <= 1'b0;
                            fade_done <= 1'b1;
                        end
                    end
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/game_render_ctrl.sv
// game_render_ctrl
//   Pixel fetch pipeline for the 2048 background image plus fade control.
//   Ports:
//     clk, reset_n                        pixel clock, async active-low reset
//     draw_x, draw_y                      current screen pixel
//     hs_in, vs_in, blank_n_in            timing generator outputs
//     frame_start, fade_in_req, fade_out_req  fade control pulses
//     rom_addr / rom_data                 image ROM (data 1 cycle after addr)
//     pal_index / pal_red,green,blue      palette lookup (combinational)
//     vga_r,g,b, vga_hs, vga_vs, vga_blank_n  DAC outputs, 3-cycle latency
//     level, busy, fade_done              fade status
module game_render_ctrl
    import game_render_pkg::*;
#(
    parameter int unsigned IMG_W       = 160,
    parameter int unsigned IMG_H       = 120,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned FADE_FRAMES = 2,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_n_in,
    input  logic              frame_start,
    input  logic              fade_in_req,
    input  logic              fade_out_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [2:0]        pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic [4:0]        level,
    output logic              busy,
    output logic              fade_done
);

    logic [9:0]          xi;
    logic [9:0]          yi;
    logic                in_img;
    logic [ADDR_W-1:0]   lin_addr;
    logic                oob;
    logic                oob_d;
    logic [PIPE_LAT-1:0] hs_pipe;
    logic [PIPE_LAT-1:0] vs_pipe;
    logic [PIPE_LAT-1:0] blank_pipe;

    assign xi       = draw_x >> SCALE_SHIFT;
    assign yi       = draw_y >> SCALE_SHIFT;
    assign in_img   = (32'(xi) < IMG_W) && (32'(yi) < IMG_H) && blank_n_in;
    assign lin_addr = ADDR_W'(32'(yi) * IMG_W + 32'(xi));

    assign pal_index   = rom_data;
    assign vga_hs      = hs_pipe[PIPE_LAT-1];
    assign vga_vs      = vs_pipe[PIPE_LAT-1];
    assign vga_blank_n = blank_pipe[PIPE_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr   <= '0;
            oob        <= 1'b0;
            oob_d      <= 1'b0;
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            hs_pipe    <= '0;
            vs_pipe    <= '0;
            blank_pipe <= '0;
        end else begin
            rom_addr   <= in_img ? lin_addr : '0;
            oob        <= !in_img;
            oob_d      <= oob;
            vga_r      <= oob_d ? '0 : scale_colour(pal_red,   level);
            vga_g      <= oob_d ? '0 : scale_colour(pal_green, level);
            vga_b      <= oob_d ? '0 : scale_colour(pal_blue,  level);
            hs_pipe    <= {hs_pipe[PIPE_LAT-2:0], hs_in};
            vs_pipe    <= {vs_pipe[PIPE_LAT-2:0], vs_in};
            blank_pipe <= {blank_pipe[PIPE_LAT-2:0], blank_n_in};
        end
    end

    fade_level_fsm #(
        .FADE_FRAMES(FADE_FRAMES)
    ) u_fade (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .fade_in_req (fade_in_req),
        .fade_out_req(fade_out_req),
        .level       (level),
        .busy        (busy),
        .fade_done   (fade_done)
    );

endmodule

// File: tb/tb_game_render_ctrl.sv
// tb_game_render_ctrl
//   Directed + randomized bench for game_render_ctrl with a synchronous ROM
//   and palette modelled here; expectations come from an arithmetic model.
module tb_game_render_ctrl;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int SHIFT = 2;
    localparam int FF    = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  draw_x, draw_y;
    logic        hs_in, vs_in, blank_n_in;
    logic        frame_start, fade_in_req, fade_out_req;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data;
    logic [2:0]  pal_index;
    logic [3:0]  pal_red, pal_green, pal_blue;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n;
    logic [4:0]  level;
    logic        busy, fade_done;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int m_level, m_dir, m_cnt;
    bit m_done;
    bit h_oob[3];
    int h_addr[3];
    bit h_hs[3], h_vs[3], h_bl[3];

    always #5 clk = ~clk;

    game_render_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .SCALE_SHIFT(SHIFT), .FADE_FRAMES(FF), .ADDR_W(15)
    ) dut (
        .clk(clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
        .frame_start(frame_start), .fade_in_req(fade_in_req), .fade_out_req(fade_out_req),
        .rom_addr(rom_addr), .rom_data(rom_data), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .level(level), .busy(busy), .fade_done(fade_done)
    );

    function automatic logic [2:0] rom_fn(input int a);
        return 3'(a + 2);
    endfunction
    function automatic logic [3:0] pr(input logic [2:0] i);
        return {i, 1'b0};
    endfunction
    function automatic logic [3:0] pg(input logic [2:0] i);
        return (i == 3'd3) ? 4'd6 : 4'(15 - int'(i));
    endfunction
    function automatic logic [3:0] pb(input logic [2:0] i);
        return (i == 3'd3) ? 4'd6 : 4'(int'(i) * 5 + 1);
    endfunction

    always @(posedge clk) rom_data <= rom_fn(int'(rom_addr));
    always_comb begin
        pal_red   = pr(pal_index);
        pal_green = pg(pal_index);
        pal_blue  = pb(pal_index);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_level = 0; m_dir = 0; m_cnt = 0; m_done = 0;
        for (int i = 0; i < 3; i++) begin
            h_oob[i] = 1; h_addr[i] = 0; h_hs[i] = 0; h_vs[i] = 0; h_bl[i] = 0;
        end
    endtask

    task automatic model_tick(input bit fs, input bit fin, input bit fout);
        m_done = 0;
        if (fout && (m_dir == 1 || (m_dir == 0 && m_level == 16))) begin
            m_dir = -1; m_cnt = 0;
        end else if (!fout && fin && (m_dir == -1 || (m_dir == 0 && m_level == 0))) begin
            m_dir = 1; m_cnt = 0;
        end else if (fs && m_dir != 0) begin
            m_cnt++;
            if (m_cnt == FF) begin
                m_cnt = 0;
                m_level = m_level + m_dir;
                if (m_level > 16) m_level = 16;
                if (m_level < 0) m_level = 0;
                if ((m_dir == 1 && m_level == 16) || (m_dir == -1 && m_level == 0)) begin
                    m_dir = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic rand_pix();
        draw_x     = 10'($urandom_range(0, 799));
        draw_y     = 10'($urandom_range(0, 524));
        blank_n_in = ($urandom_range(0, 7) != 0);
        hs_in      = 1'($urandom_range(0, 1));
        vs_in      = 1'($urandom_range(0, 1));
    endtask

    // One pixel clock: apply inputs, advance, check every output against the model.
    task automatic step(input bit fs, input bit fin, input bit fout);
        int lvl_prev = m_level;
        int xi = int'(draw_x) >> SHIFT;
        int yi = int'(draw_y) >> SHIFT;
        bit oob = (xi >= IMG_W) || (yi >= IMG_H) || !blank_n_in;
        logic [2:0] idx;
        frame_start = fs; fade_in_req = fin; fade_out_req = fout;
        for (int i = 2; i > 0; i--) begin
            h_oob[i] = h_oob[i-1]; h_addr[i] = h_addr[i-1];
            h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1]; h_bl[i] = h_bl[i-1];
        end
        h_oob[0] = oob;
        h_addr[0] = oob ? 0 : (yi * IMG_W + xi) % 32768;
        h_hs[0] = hs_in; h_vs[0] = vs_in; h_bl[0] = blank_n_in;
        @(posedge clk); #1;
        frame_start = 0; fade_in_req = 0; fade_out_req = 0;
        model_tick(fs, fin, fout);
        idx = rom_fn(h_addr[2]);
        chk("rom_addr", 32'(rom_addr), 32'(h_addr[0]));
        chk("vga_r", 32'(vga_r), h_oob[2] ? 0 : 32'((int'(pr(idx)) * lvl_prev) / 16));
        chk("vga_g", 32'(vga_g), h_oob[2] ? 0 : 32'((int'(pg(idx)) * lvl_prev) / 16));
        chk("vga_b", 32'(vga_b), h_oob[2] ? 0 : 32'((int'(pb(idx)) * lvl_prev) / 16));
        chk("vga_hs", 32'(vga_hs), 32'(h_hs[2]));
        chk("vga_vs", 32'(vga_vs), 32'(h_vs[2]));
        chk("vga_blank_n", 32'(vga_blank_n), 32'(h_bl[2]));
        chk("level", 32'(level), 32'(m_level));
        chk("busy", 32'(busy), 32'(m_dir != 0));
        chk("fade_done", 32'(fade_done), 32'(m_done));
    endtask

    task automatic async_reset();
        #2 reset_n = 0;
        #1 reset_model();
        @(posedge clk); #1 reset_n = 1;
    endtask

    task automatic frames(input int n, output int dones);
        dones = 0;
        for (int f = 0; f < n; f++) begin
            rand_pix(); step(1, 0, 0);
            if (fade_done) dones++;
            repeat (2) begin rand_pix(); step(0, 0, 0); end
        end
    endtask

    initial begin
        int  dn;
        bit  seen8 = 0;
        reset_n = 0; draw_x = 0; draw_y = 0; hs_in = 0; vs_in = 0; blank_n_in = 0;
        frame_start = 0; fade_in_req = 0; fade_out_req = 0;
        reset_model();
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_vga_r", 32'(vga_r), 0);
        chk("rst_vga_g", 32'(vga_g), 0);
        chk("rst_vga_b", 32'(vga_b), 0);
        chk("rst_sync", 32'({vga_hs, vga_vs, vga_blank_n}), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(fade_done), 0);
        @(posedge clk); #1; @(posedge clk); #1 reset_n = 1;

        repeat (20) begin rand_pix(); step(0, 0, 0); end

        // fade in: 32 frame_starts, one step every 2 frames
        rand_pix(); step(0, 1, 0);
        chk("fadein_busy", 32'(busy), 1);
        dn = 0;
        for (int f = 0; f < 32; f++) begin
            rand_pix(); step(1, 0, 0);
            if (fade_done) dn++;
            if (f < 31) chk("fadein_busy_run", 32'(busy), 1);
            if (m_level == 8 && !seen8) begin
                seen8 = 1;
                draw_x = 5; draw_y = 9; blank_n_in = 1;
                step(0, 0, 0);
                rand_pix(); step(0, 0, 0);
                rand_pix(); step(0, 0, 0);
                chk("lvl8_r", 32'(vga_r), 3);
                chk("lvl8_g", 32'(vga_g), 3);
                chk("lvl8_b", 32'(vga_b), 3);
            end
        end
        chk("fadein_done_cnt", 32'(dn), 1);
        chk("fadein_level", 32'(level), 16);
        chk("fadein_busy_end", 32'(busy), 0);

        // address map at full brightness
        draw_x = 5; draw_y = 9; blank_n_in = 1; hs_in = 1;
        step(0, 0, 0);
        chk("addr_321", 32'(rom_addr), 321);
        rand_pix(); hs_in = 0; step(0, 0, 0);
        rand_pix(); hs_in = 0; step(0, 0, 0);
        chk("shown_r", 32'(vga_r), 6);
        chk("shown_g", 32'(vga_g), 6);
        chk("shown_b", 32'(vga_b), 6);
        chk("shown_hs", 32'(vga_hs), 1);

        // out of image and blanked pixels
        draw_x = 20; draw_y = 480; blank_n_in = 1;
        step(0, 0, 0);
        chk("oob_addr", 32'(rom_addr), 0);
        rand_pix(); step(0, 0, 0); rand_pix(); step(0, 0, 0);
        chk("oob_r", 32'(vga_r), 0);
        draw_x = 5; draw_y = 9; blank_n_in = 0;
        step(0, 0, 0);
        chk("blank_addr", 32'(rom_addr), 0);
        rand_pix(); step(0, 0, 0); rand_pix(); step(0, 0, 0);
        chk("blank_g", 32'(vga_g), 0);

        // fade out to black, then reversal from level 5
        rand_pix(); step(0, 0, 1);
        frames(32, dn);
        chk("fadeout_done", 32'(dn), 1);
        chk("fadeout_level", 32'(level), 0);
        rand_pix(); step(0, 1, 0);
        frames(10, dn);
        chk("rev_level5", 32'(level), 5);
        rand_pix(); step(0, 0, 1);
        chk("rev_busy", 32'(busy), 1);
        frames(10, dn);
        chk("rev_level0", 32'(level), 0);
        chk("rev_done", 32'(dn), 1);
        chk("rev_busy_end", 32'(busy), 0);

        // simultaneous requests and frame_start mid-count
        rand_pix(); step(0, 1, 0);
        frames(5, dn);
        chk("sim_pre_level", 32'(level), 2);
        rand_pix(); step(1, 1, 1);
        chk("sim_level", 32'(level), 2);
        chk("sim_busy", 32'(busy), 1);
        rand_pix(); step(1, 0, 0);
        chk("sim_cnt_clear", 32'(level), 2);
        rand_pix(); step(1, 0, 0);
        chk("sim_first_step", 32'(level), 1);
        frames(2, dn);
        chk("sim_black", 32'(level), 0);

        // randomized control traffic
        for (int i = 0; i < 1500; i++) begin
            rand_pix();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end

        // reset mid-fade at level 9
        async_reset();
        rand_pix(); step(0, 1, 0);
        frames(18, dn);
        chk("mid_level9", 32'(level), 9);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(fade_done), 0);
        chk("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
        chk("mid_rst_sync", 32'({vga_hs, vga_vs, vga_blank_n}), 0);
        reset_model();
        @(posedge clk); #1 reset_n = 1;
        rand_pix(); step(1, 0, 0);
        rand_pix(); step(1, 0, 0);
        chk("post_rst_level", 32'(level), 0);
        repeat (5) begin rand_pix(); step(0, 0, 0); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
